bcd_cmd_gen: RTL

Command generator for the BCD counter's control interface. Takes four raw, bouncing pushbutton inputs and turns each clean press into exactly one single-cycle, one-hot command pulse on up/down/set9/set0. The counter's case decode only acts on those four one-hot codes. The block sits between the board buttons and the counter's control inputs, in the same clk domain.

---
 rtl/bcd_cmd_gen_if.sv | 23 ++
 rtl/bcd_cmd_gen.sv | 125 ++++++++++++
 2 files changed

// File: rtl/bcd_cmd_gen_if.sv
// Button/command bundle between the board pushbuttons and the BCD counter.
// The master drives the raw buttons and observes the commands; the slave
// (bcd_cmd_gen) does the reverse.
interface bcd_cmd_gen_if;
  logic btn_up;
  logic btn_down;
  logic btn_set9;
  logic btn_set0;
  logic up;
  logic down;
  logic set9;
  logic set0;

  modport master (
    output btn_up, btn_down, btn_set9, btn_set0,
    input  up, down, set9, set0
  );

  modport slave (
    input  btn_up, btn_down, btn_set9, btn_set0,
    output up, down, set9, set0
  );
endinterface

// File: rtl/bcd_cmd_gen.sv
// Turns four raw, bouncing pushbuttons into single-cycle, one-hot commands
// for the BCD counter. Each button is synchronized, then debounced; a
// three-state FSM fires one command per clean press, using the priority
// set0 > set9 > up > down.
// Bit order of every 4-bit vector below: [3]=set0 [2]=set9 [1]=down [0]=up.
module bcd_cmd_gen #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 16
) (
  input logic         clk,
  input logic         rst_n,
  bcd_cmd_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRE,
    S_HOLD
  } state_t;

  logic [3:0]       w_btn;
  logic [3:0]       r_s1;
  logic [3:0]       r_s2;
  logic [3:0]       r_stb;
  logic [CNT_W-1:0] r_cnt [4];

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cmd;
  logic [3:0]       w_cmd_nxt;
  logic [3:0]       r_held;
  logic [3:0]       w_held_nxt;
  logic [3:0]       w_pick;

  assign w_btn = {bus.btn_set0, bus.btn_set9, bus.btn_down, bus.btn_up};

  // Two-flop synchronizer for the asynchronous button levels.
  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // with = here r_s2 would pick up the new r_s1 and the second stage would vanish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_btn;
      r_s2 <= r_s1;
    end
  end

  // Per-button debounce: a level change must persist DB_CYCLES edges; any
  // bounce back to the stable level restarts the count.
  // NOTE: the counter array is reset element by element; it is a handful of
  // flops, not a RAM, and a press held through reset must restart from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stb <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_s2[i] == r_stb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_stb[i] <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Fixed-priority pick among debounced presses: set0 > set9 > up > down.
  always_comb begin
    if      (r_stb[3]) w_pick = 4'b1000;
    else if (r_stb[2]) w_pick = 4'b0100;
    else if (r_stb[0]) w_pick = 4'b0001;
    else if (r_stb[1]) w_pick = 4'b0010;
    else               w_pick = 4'b0000;
  end

  // Next-state and next-command logic. HOLD waits for the button that fired
  // to release; any other button still pressed then fires from IDLE.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = '0;
    w_held_nxt  = r_held;
    case (r_state)
      S_IDLE: begin
        if (|r_stb) begin
          w_state_nxt = S_FIRE;
          w_cmd_nxt   = w_pick;
          w_held_nxt  = w_pick;
        end
      end
      S_FIRE: w_state_nxt = S_HOLD;
      S_HOLD: begin
        if ((r_stb & r_held) == 4'b0000) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, registered command outputs and the record of which button fired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cmd   <= '0;
      r_held  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cmd   <= w_cmd_nxt;
      r_held  <= w_held_nxt;
    end
  end

  assign bus.up   = r_cmd[0];
  assign bus.down = r_cmd[1];
  assign bus.set9 = r_cmd[2];
  assign bus.set0 = r_cmd[3];

endmodule
